// File: rtl/dsp48a1_mac_seq.sv
// -----------------------------------------------------------------------------
// dsp48a1_mac_seq
//
// Sequencer that runs one DSP48A1 slice as a signed multiply-accumulate engine.
// A command gives the number of terms N. The block streams N (A,B) operand
// pairs into the slice with the right OPMODE per beat. Once the slice pipeline
// has drained it returns sum(A*B), wrapped to 48 bits.
//
// Expected slice configuration: A1REG=B1REG=MREG=PREG=OPMODEREG=1,
// A0/B0/D/C registers off, B operand taken from the B port.
//
// Optional feature macro: BIAS_EN
//   defined   : adds a 48-bit 'bias' input, which is sampled on command accept
//               and driven on dsp_c. The first beat uses Z=C, so the sum starts
//               from the bias. N=0 returns the bias.
//   undefined : no bias port. dsp_c is tied to zero.
//
// Parameters
//   LEN_W    width of cmd_len (max terms 2^LEN_W-1)
//   DSP_LAT  clock edges from operands on dsp_a/dsp_b to dsp_p reflecting them
//   OPM_SKEW cycles dsp_opmode lags the dsp_a/dsp_b beat it belongs to
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   cmd_valid/ready/len   command handshake (ready only in IDLE), term count
//   bias                  accumulation start value (BIAS_EN only)
//   in_valid/ready/a/b    operand stream (ready only in ACCUM), 18-bit signed
//   res_valid/ready       result handshake, result held until accepted
//   res_data, res_carry   48-bit sum and slice CARRYOUT captured with it
//   busy                  state != IDLE
//   dsp_a, dsp_b, dsp_c   slice operand ports
//   dsp_opmode, dsp_ce    slice OPMODE and shared clock enable
//   dsp_rst               shared slice reset (mirrors RST)
//   dsp_p, dsp_carryout   slice results
// -----------------------------------------------------------------------------
// state   | meaning
// --------+-------------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high, slice clock-enable off
// S_ACCUM | accepting operand pairs, one beat (pair or zero bubble) per cycle
// S_DRAIN | last beat issued, waiting DSP_LAT+1 cycles for P to settle
// S_DONE  | result presented, waiting for res_ready, slice frozen
// -----------------------------------------------------------------------------
module dsp48a1_mac_seq #(
    parameter int LEN_W    = 8,
    parameter int DSP_LAT  = 3,
    parameter int OPM_SKEW = 1
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
`ifdef BIAS_EN
    input  logic [47:0]      bias,
`endif

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             res_carry,
    output logic             busy,

    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_c,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout
);

    // OPMODE encodings: X=M in bits [1:0], Z select in bits [3:2].
    localparam logic [7:0] OPM_ACC = 8'b0000_1001;   // P = M + P
`ifdef BIAS_EN
    localparam logic [7:0] OPM_FIRST = 8'b0000_1101; // P = M + C
`else
    localparam logic [7:0] OPM_FIRST = 8'b0000_0001; // P = M
`endif

    localparam int DRN_W = (DSP_LAT < 1) ? 1 : $clog2(DSP_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [LEN_W-1:0]   beat_cnt;      // pairs still to accept
    logic [DRN_W-1:0]   drain_cnt;
    logic               first_pend;    // no pair accepted yet in this command
    logic [47:0]        bias_q;

    logic               cmd_ready_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               dsp_ce_q;
    logic               res_valid_q;
    logic [47:0]        res_data_q;
    logic               res_carry_q;
    logic [17:0]        dsp_a_q;
    logic [17:0]        dsp_b_q;

    // Stage 0 is aligned with dsp_a/dsp_b. The last stage drives the slice,
    // so each OPMODE reaches the slice's OPMODE register one cycle after its
    // operands reach A1/B1. That is where the P stage expects it.
    logic [7:0]         opm_pipe [0:OPM_SKEW];

    logic               cmd_fire;
    logic               in_fire;
    logic               beat_last;
    logic               drain_tc;
    logic [47:0]        bias_in;

`ifdef BIAS_EN
    assign bias_in = bias;
`else
    assign bias_in = '0;
`endif

    assign cmd_fire  = cmd_valid & cmd_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign beat_last = (beat_cnt == LEN_W'(1));
    assign drain_tc  = (drain_cnt == '0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = (cmd_len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_fire && beat_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_tc) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (res_valid_q && res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------- control / data
    // Handshake and status outputs are registered from the next state. They
    // therefore track the state register exactly and read 0 while RST is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            dsp_ce_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            first_pend  <= 1'b0;
            bias_q      <= '0;
        end else begin
            cmd_ready_q <= (state_nxt == S_IDLE);
            in_ready_q  <= (state_nxt == S_ACCUM);
            busy_q      <= (state_nxt != S_IDLE);
            dsp_ce_q    <= (state_nxt == S_ACCUM) || (state_nxt == S_DRAIN);
            res_valid_q <= (state_nxt == S_DONE);

            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        beat_cnt   <= cmd_len;
                        first_pend <= 1'b1;
                        bias_q     <= bias_in;
                        if (cmd_len == '0) begin
                            res_data_q  <= bias_in;
                            res_carry_q <= 1'b0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_fire) begin
                        beat_cnt   <= beat_cnt - LEN_W'(1);
                        first_pend <= 1'b0;
                        if (beat_last) begin
                            drain_cnt <= DRN_W'(DSP_LAT);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_tc) begin
                        // dsp_p now reflects the last beat. On this edge the
                        // slice also absorbs a zero bubble, so sample now.
                        res_data_q  <= dsp_p;
                        res_carry_q <= dsp_carryout;
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ beat issue
    // Every ACCUM cycle issues a beat. A cycle without an accepted pair
    // issues zero operands, which add nothing. Until the first pair lands,
    // the beat uses the first-beat OPMODE. This drops stale P from an earlier
    // command and any pipeline garbage ahead of it. DRAIN issues zero beats
    // with Z=P so P holds the sum until capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dsp_a_q <= '0;
            dsp_b_q <= '0;
            for (int i = 0; i <= OPM_SKEW; i++) begin
                opm_pipe[i] <= '0;
            end
        end else begin
            if ((state == S_ACCUM) && in_fire) begin
                dsp_a_q <= in_a;
                dsp_b_q <= in_b;
            end else begin
                dsp_a_q <= '0;
                dsp_b_q <= '0;
            end

            case (state)
                S_ACCUM: opm_pipe[0] <= first_pend ? OPM_FIRST : OPM_ACC;
                S_DRAIN: opm_pipe[0] <= OPM_ACC;
                default: opm_pipe[0] <= '0;
            endcase

            for (int i = 1; i <= OPM_SKEW; i++) begin
                opm_pipe[i] <= opm_pipe[i-1];
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign cmd_ready  = cmd_ready_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_carry  = res_carry_q;
    assign dsp_a      = dsp_a_q;
    assign dsp_b      = dsp_b_q;
    assign dsp_opmode = opm_pipe[OPM_SKEW];
    assign dsp_ce     = dsp_ce_q;
    assign dsp_rst    = RST;
`ifdef BIAS_EN
    assign dsp_c      = bias_q;
`else
    assign dsp_c      = '0;
`endif

    // ------------------------------------------------------------ properties
    a_ready_excl: assert property (@(posedge CLK) disable iff (RST)
        !(cmd_ready_q && in_ready_q));

    a_res_hold: assert property (@(posedge CLK) disable iff (RST)
        (res_valid_q && !res_ready) |=> (res_valid_q && $stable(res_data_q)
                                         && $stable(res_carry_q)));

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
module tb_dsp48a1_mac_seq;

    localparam int LEN_W    = 8;
    localparam int DSP_LAT  = 3;
    localparam int OPM_SKEW = 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
`ifdef BIAS_EN
    logic [47:0]      bias = '0;
`endif
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [17:0]      in_a = '0;
    logic [17:0]      in_b = '0;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;
    logic             res_carry;
    logic             busy;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [47:0]      dsp_c;
    logic [7:0]       dsp_opmode;
    logic             dsp_ce;
    logic             dsp_rst;
    logic [47:0]      dsp_p;
    logic             dsp_carryout;

    always #5 CLK = ~CLK;

    dsp48a1_mac_seq #(
        .LEN_W    (LEN_W),
        .DSP_LAT  (DSP_LAT),
        .OPM_SKEW (OPM_SKEW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
`ifdef BIAS_EN
        .bias         (bias),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_carry    (res_carry),
        .busy         (busy),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_c        (dsp_c),
        .dsp_opmode   (dsp_opmode),
        .dsp_ce       (dsp_ce),
        .dsp_rst      (dsp_rst),
        .dsp_p        (dsp_p),
        .dsp_carryout (dsp_carryout)
    );

    // ---------------- DSP48A1 slice stand-in (A1/B1, M, OPMODE, P registers)
    logic signed [17:0] s_a1, s_b1;
    logic signed [35:0] s_m;
    logic [7:0]         s_opm;
    logic [47:0]        s_x, s_z;
    logic [48:0]        s_sum;

    always_comb begin
        s_x = (s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
        case (s_opm[3:2])
            2'b10:   s_z = dsp_p;
            2'b11:   s_z = dsp_c;
            default: s_z = 48'd0;
        endcase
        s_sum = {1'b0, s_z} + {1'b0, s_x};
    end

    always @(posedge CLK) begin
        if (dsp_rst) begin
            s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0;
            dsp_p <= '0; dsp_carryout <= 1'b0;
        end else if (dsp_ce) begin
            s_a1  <= dsp_a;
            s_b1  <= dsp_b;
            s_m   <= s_a1 * s_b1;
            s_opm <= dsp_opmode;
            dsp_p        <= s_sum[47:0];
            dsp_carryout <= s_sum[48];
        end
    end

    // ---------------- bookkeeping
    typedef struct {
        logic [47:0] data;
        logic        carry;
        int          rise;
    } exp_t;

    exp_t exp_q[$];
    int   op_a[$];
    int   op_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ready_mode = 2;   // 0 random, 1 hold low, 2 always high

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting, cycle %0d", name, cyc);
    endtask

    // Reference: sum of signed products, 48-bit wrap, starting from bias.
    // The carry is the carry-out of the final 48-bit addition.
    function automatic exp_t model(input int n, input logic [47:0] bias_v);
        exp_t        e;
        logic [48:0] acc;
        longint      p;
        acc = {1'b0, bias_v};
        for (int i = 0; i < n; i++) begin
            p   = longint'(op_a[i]) * longint'(op_b[i]);
            acc = {1'b0, acc[47:0]} + {1'b0, p[47:0]};
        end
        e.data  = acc[47:0];
        e.carry = (n > 0) ? acc[48] : 1'b0;
        e.rise  = 0;
        return e;
    endfunction

    // ---------------- result ready driver
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       res_ready = ($urandom_range(0, 3) != 0);
                1:       res_ready = 1'b0;
                default: res_ready = 1'b1;
            endcase
        end
    end

    // ---------------- expected beat issue, sampled at the accepting edge
    logic        iss_chk = 1'b0;
    logic [17:0] iss_a = '0;
    logic [17:0] iss_b = '0;
    always @(posedge CLK) begin
        iss_chk <= in_ready && !RST;
        iss_a   <= (in_valid && in_ready) ? in_a : 18'd0;
        iss_b   <= (in_valid && in_ready) ? in_b : 18'd0;
    end

    // ---------------- monitor / scoreboard
    initial begin
        logic        prev_valid;
        logic        prev_hold;
        logic [47:0] prev_data;
        logic        prev_carry;
        exp_t        e;
        prev_valid = 1'b0;
        prev_hold  = 1'b0;
        prev_data  = '0;
        prev_carry = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                chk("ready_exclusive", {63'd0, cmd_ready && in_ready}, 64'd0);
                if (iss_chk) begin
                    chk("beat_a", {46'd0, dsp_a}, {46'd0, iss_a});
                    chk("beat_b", {46'd0, dsp_b}, {46'd0, iss_b});
                end
                if (prev_hold) begin
                    chk("hold_valid", {63'd0, res_valid}, 64'd1);
                    chk("hold_data", {15'd0, res_carry, res_data}, {15'd0, prev_carry, prev_data});
                    chk("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
                end
                if (res_valid && !prev_valid) begin
                    if (exp_q.size() == 0) timeout_fail("unexpected_result");
                    else chk("result_latency", 64'(cyc), 64'(exp_q[0].rise));
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_handshake");
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", {16'd0, res_data}, {16'd0, e.data});
                        chk("res_carry", {63'd0, res_carry}, {63'd0, e.carry});
                    end
                end
                prev_valid = res_valid;
                prev_hold  = res_valid && !res_ready;
                prev_data  = res_data;
                prev_carry = res_carry;
            end else begin
                prev_valid = 1'b0;
                prev_hold  = 1'b0;
            end
        end
    end

    // ---------------- stimulus
    task automatic set_bias(input logic [47:0] v);
`ifdef BIAS_EN
        bias = v;
`else
        if (v != 48'd0) $display("note: bias ignored in this build");
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {30'd0, cmd_ready, in_ready, res_valid, res_carry, busy, dsp_ce,
                   dsp_a, dsp_b, dsp_opmode},
            64'd0);
        chk({name, "_wide"}, {16'd0, res_data | dsp_c}, 64'd0);
        chk({name, "_dsp_rst"}, {63'd0, dsp_rst}, 64'd1);
    endtask

    // Issues one command with the operands in op_a/op_b. If use_const is set,
    // the expectation is given explicitly, otherwise it comes from the model.
    task automatic run_cmd(input int n, input int gap, input bit rnd_gap,
                           input logic [47:0] bias_v, input int abort_at,
                           input bit use_const, input logic [47:0] c_data,
                           input logic c_carry);
        exp_t e;
        int   t;
        int   g;
        logic r;
        t = 0;
        @(negedge CLK);
        while (!cmd_ready && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (!cmd_ready) begin
            timeout_fail("cmd_ready_wait");
            return;
        end
        e = model(n, bias_v);
        if (use_const) begin
            e.data  = c_data;
            e.carry = c_carry;
        end
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(n);
        set_bias(bias_v);
        if (n == 0) begin
            e.rise = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_len   = '0;
        if (n == 0) begin
            chk("n0_dsp_ce", {63'd0, dsp_ce}, 64'd0);
            chk("n0_busy", {63'd0, busy}, 64'd1);
            chk("n0_res_valid", {63'd0, res_valid}, 64'd1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                RST = 1'b1;
                @(negedge CLK);
                check_reset_outputs("abort_reset");
                RST = 1'b0;
                return;
            end
            g = rnd_gap ? $urandom_range(0, gap) : ((i > 0) ? gap : 0);
            repeat (g) @(negedge CLK);
            in_valid = 1'b1;
            in_a     = 18'(op_a[i]);
            in_b     = 18'(op_b[i]);
            t = 0;
            do begin
                r = in_ready;
                @(negedge CLK);
                t++;
            end while (!r && t < 300);
            in_valid = 1'b0;
            if (!r) begin
                timeout_fail("in_ready_wait");
                return;
            end
        end
        e.rise = cyc + DSP_LAT + 1;
        exp_q.push_back(e);
    endtask

    task automatic load_ops3();
        op_a = {2, 4, 6};
        op_b = {3, 5, 7};
    endtask

    initial begin
        int t;
        int n;
        logic [47:0] bv;

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset_state");
        RST = 1'b0;

        ready_mode = 2;
        load_ops3();
        run_cmd(3, 0, 1'b0, 48'd0, -1, 1'b1, 48'h44, 1'b0);
        run_cmd(3, 2, 1'b0, 48'd0, -1, 1'b1, 48'h44, 1'b0);

        op_a = {-1};
        op_b = {1};
        run_cmd(1, 0, 1'b0, 48'd0, -1, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0);
        run_cmd(0, 0, 1'b0, 48'd0, -1, 1'b1, 48'd0, 1'b0);

        ready_mode = 1;
        load_ops3();
        run_cmd(3, 0, 1'b0, 48'd0, -1, 1'b1, 48'h44, 1'b0);
        t = 0;
        while (!res_valid && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!res_valid) timeout_fail("hold_result_wait");
        repeat (5) @(negedge CLK);
        ready_mode = 2;

        op_a = {11, -7, 300, 5};
        op_b = {13, 9, -2, 8};
        run_cmd(4, 0, 1'b0, 48'd0, 2, 1'b0, 48'd0, 1'b0);
        op_a = {3};
        op_b = {3};
        run_cmd(1, 0, 1'b0, 48'd0, -1, 1'b1, 48'd9, 1'b0);

`ifdef BIAS_EN
        op_a = {3};
        op_b = {4};
        run_cmd(1, 0, 1'b0, 48'd100, -1, 1'b1, 48'd112, 1'b0);
        run_cmd(0, 0, 1'b0, 48'd100, -1, 1'b1, 48'd100, 1'b0);
`endif

        ready_mode = 0;
        for (int k = 0; k < 24; k++) begin
            n = $urandom_range(0, 8);
            op_a.delete();
            op_b.delete();
            for (int i = 0; i < n; i++) begin
                op_a.push_back(int'($urandom_range(0, 262143)) - 131072);
                op_b.push_back(int'($urandom_range(0, 262143)) - 131072);
            end
`ifdef BIAS_EN
            bv = {$urandom, $urandom} >> 16;
`else
            bv = 48'd0;
`endif
            run_cmd(n, 3, 1'b1, bv, -1, 1'b0, 48'd0, 1'b0);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        if (exp_q.size() != 0) timeout_fail("drain_scoreboard");
        repeat (3) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
